// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-queue definitions: default word width, PC increment, reset PC and word type.
package instr_fetch_queue_pkg;

  localparam int unsigned IFQ_XLEN   = 32;
  localparam int unsigned IFQ_PC_INC = 4;
  localparam logic [IFQ_XLEN-1:0] IFQ_RESET_PC = '0;

  typedef logic [IFQ_XLEN-1:0] ifq_word_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response channel plus decode-side valid/ready output.
interface instr_fetch_queue_if
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN = IFQ_XLEN
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// ifq_fifo: synchronous FIFO with flush and occupancy count; push and pop may coincide when full.
module ifq_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_pop   = i_pop & (r_count != '0);
  assign w_push  = i_push & ((r_count != CW'(DEPTH)) | w_pop);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC generator with credit-limited imem requests, in-order instruction queue,
// redirect flush with in-flight discard, and halt. IFQ_PERF_CNT_EN adds fetch/flush/drop counters.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned    XLEN      = IFQ_XLEN,
  parameter int unsigned    DEPTH     = 4,
  parameter int unsigned    MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFQ_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt,
  input  logic               branch_en,
  input  logic [XLEN-1:0]    branch_addr,
  output logic               branch_taken,
`ifdef IFQ_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt,
  output logic [31:0]        perf_drop_cnt,
`endif
  instr_fetch_queue_if.master bus
);

  localparam int unsigned QCW = $clog2(DEPTH + 1);
  localparam int unsigned OCW = $clog2(MAX_OUTST + 1);

  logic [XLEN-1:0]   r_fetch_pc;
  logic [OCW-1:0]    r_drop;
  logic              r_req_hold;

  logic [QCW-1:0]    w_q_count;
  logic [OCW-1:0]    w_outst;
  logic [QCW:0]      w_used;
  logic              w_credit;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp_drop;
  logic              w_q_push;
  logic [XLEN-1:0]   w_rsp_pc;
  logic [2*XLEN-1:0] w_q_head;
  logic [XLEN-1:0]   w_branch_tgt;

  // Credit: every issued request must already own a queue slot, so responses never stall.
  assign w_used      = (QCW+1)'(w_outst) + (QCW+1)'(w_q_count);
  assign w_credit    = (w_used < (QCW+1)'(DEPTH)) & (w_outst < OCW'(MAX_OUTST));
  assign w_req_valid = ~branch_en & (r_req_hold | (~halt & w_credit));
  assign w_req_fire  = w_req_valid & bus.imem_req_ready;

  // A response is stale if an earlier redirect marked it, or a redirect arrives with it.
  assign w_rsp_drop   = bus.imem_rsp_valid & ((r_drop != '0) | branch_en);
  assign w_q_push     = bus.imem_rsp_valid & ~w_rsp_drop;
  assign w_branch_tgt = branch_addr & ~XLEN'(3);

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.out_valid      = (w_q_count != '0);
  assign bus.out_pc         = w_q_head[2*XLEN-1:XLEN];
  assign bus.out_instr      = w_q_head[XLEN-1:0];

  // In-flight PC tracker; its occupancy doubles as the outstanding-request count.
  ifq_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_req_fire),
    .i_data  (r_fetch_pc),
    .i_pop   (bus.imem_rsp_valid),
    .i_flush (1'b0),
    .o_data  (w_rsp_pc),
    .o_count (w_outst)
  );

  ifq_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_q_push),
    .i_data  ({w_rsp_pc, bus.imem_rsp_data}),
    .i_pop   (bus.out_ready),
    .i_flush (branch_en),
    .o_data  (w_q_head),
    .o_count (w_q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc   <= RESET_PC;
      r_drop       <= '0;
      r_req_hold   <= 1'b0;
      branch_taken <= 1'b0;
    end else begin
      r_req_hold   <= w_req_valid & ~bus.imem_req_ready;
      branch_taken <= branch_en;
      if (branch_en) begin
        // Everything still in flight after this cycle's response belongs to the old path.
        r_fetch_pc <= w_branch_tgt;
        r_drop     <= w_outst - OCW'(bus.imem_rsp_valid);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(IFQ_PC_INC);
        if (w_rsp_drop) r_drop     <= r_drop - OCW'(1);
      end
    end
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(w_req_fire);
      perf_flush_cnt <= perf_flush_cnt + 32'(branch_en);
      perf_drop_cnt  <= perf_drop_cnt + 32'(w_rsp_drop);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised self-checking bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;

  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b1;
  logic        branch_en = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        branch_taken;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_drop_cnt;
`endif

  instr_fetch_queue_if #(.XLEN(XLEN)) bus ();

  instr_fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .halt         (halt),
    .branch_en    (branch_en),
    .branch_addr  (branch_addr),
    .branch_taken (branch_taken),
`ifdef IFQ_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: fetch PC, in-flight addresses, queued words.
  logic [31:0] m_pc;
  infl_t       infl[$];
  ent_t        q[$];
  bit          m_hold;
  bit          m_taken;
  int unsigned m_fetches, m_flushes, m_drops;

  function automatic ifq_word_t mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_pc = 32'h0; infl.delete(); q.delete();
    m_hold = 0; m_taken = 0;
    m_fetches = 0; m_flushes = 0; m_drops = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; halt = 1'b1; branch_en = 1'b0; branch_addr = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0; bus.out_ready = 1'b0;
    model_clear();
    @(negedge clk); #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check("rst_req_addr", bus.imem_req_addr, 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_branch_taken", 32'(branch_taken), 32'h0);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit br, input logic [31:0] ba, input bit h, input bit rdy,
                      input bit ordy, input int rsp_pct);
    bit          rsp, exp_rv, fire;
    logic [31:0] rd;
    infl_t       e;
    ent_t        ne;
    @(negedge clk);
    rsp = (infl.size() > 0) && (int'($urandom_range(0, 99)) < rsp_pct);
    rd  = rsp ? mem_data(infl[0].pc) : $urandom;
    branch_en = br; branch_addr = ba; halt = h;
    bus.imem_req_ready = rdy; bus.out_ready = ordy;
    bus.imem_rsp_valid = rsp; bus.imem_rsp_data = rd;
    #1;
    exp_rv = !br && (m_hold || (!h && (infl.size() + q.size() < DEPTH) && (infl.size() < MAX_OUTST)));
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    check("req_addr", bus.imem_req_addr, m_pc);
    check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_pc", bus.out_pc, q[0].pc);
      check("out_instr", bus.out_instr, q[0].instr);
    end
    check("branch_taken", 32'(branch_taken), 32'(m_taken));
`ifdef IFQ_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, m_fetches);
    check("perf_flush", perf_flush_cnt, m_flushes);
    check("perf_drop", perf_drop_cnt, m_drops);
`endif
    fire = exp_rv && rdy;
    if (br) q.delete();
    else if (ordy && q.size() > 0) void'(q.pop_front());
    if (rsp) begin
      e = infl.pop_front();
      if (e.stale || br) m_drops++;
      else begin ne.pc = e.pc; ne.instr = rd; q.push_back(ne); end
    end
    if (fire) begin
      e.pc = m_pc; e.stale = 1'b0; infl.push_back(e);
      m_pc = m_pc + 32'd4; m_fetches++;
    end
    if (br) begin
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pc = {ba[31:2], 2'b00}; m_flushes++;
    end
    m_hold  = exp_rv && !rdy;
    m_taken = br;
  endtask

  initial begin
    bit found;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0; bus.out_ready = 1'b0;

    // Streaming fetch with single-cycle memory.
    do_reset();
    repeat (10) step(0, 0, 0, 1, 1, 100);
    check("t1_next_pc", m_pc, 32'h28);
    check("t1_head_pc", (q.size() > 0) ? q[0].pc : 32'hDEAD_BEEF, 32'h20);

    // Decode stalled: queue fills to DEPTH and fetch stops at 0x10.
    do_reset();
    repeat (12) step(0, 0, 0, 1, 0, 100);
    check("t2_q_size", q.size(), 32'd4);
    check("t2_next_pc", m_pc, 32'h10);
    repeat (2) step(0, 0, 0, 1, 1, 100);
    check("t2_resume_addr", (infl.size() > 0) ? infl[0].pc : 32'hDEAD_BEEF, 32'h10);
    repeat (6) step(0, 0, 0, 1, 1, 100);

    // Redirect with two requests in flight.
    do_reset();
    repeat (2) step(0, 0, 0, 1, 1, 0);
    check("t3_outstanding", infl.size(), 32'd2);
    step(1, 32'h103, 0, 1, 1, 0);
    check("t3_redirect_pc", m_pc, 32'h100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 1, 0, 100);
      found = (q.size() > 0);
    end
    check("t3_first_pc", (q.size() > 0) ? q[0].pc : 32'hDEAD_BEEF, 32'h100);
    check("t3_drops", m_drops, 32'd2);
    repeat (4) step(0, 0, 0, 1, 1, 100);

    // Halt cannot withdraw a pending request; nothing new afterwards.
    do_reset();
    step(0, 0, 0, 0, 1, 100);
    repeat (3) step(0, 0, 1, 0, 1, 100);
    step(0, 0, 1, 1, 1, 100);
    repeat (6) step(0, 0, 1, 1, 1, 100);
    check("t4_pc_held", m_pc, 32'h4);
    check("t4_drained", infl.size() + q.size(), 32'd0);

    // Address wrap at the top of the space.
    step(1, 32'hFFFF_FFFE, 0, 1, 1, 100);
    step(0, 0, 0, 1, 1, 100);
    check("t5_wrap_pc", m_pc, 32'h0);
    repeat (3) step(0, 0, 0, 1, 1, 100);

    // Redirect under halt with a live response landing the same cycle.
    do_reset();
    step(0, 0, 0, 1, 1, 0);
    step(1, 32'h200, 1, 1, 1, 100);
    check("t6_drops", m_drops, 32'd1);
    check("t6_redirect_pc", m_pc, 32'h200);
    repeat (4) step(0, 0, 0, 1, 1, 100);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 5), $urandom, ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70),
           int'($urandom_range(20, 100)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
